// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller and the datapath:
// opcode constants, FSM state codes, next-PC (Jump) encodings, branch
// condition selects and the packed control vector produced by ctrl_decode.
// Optional build macro used elsewhere: CTRL_ILLEGAL_TRAP_EN (trap undefined
// opcodes into HALT instead of running them as a NOP).
package multicycle_controller_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_ADDI = 5'd2;
    localparam logic [4:0] OP_CMP  = 5'd3;
    localparam logic [4:0] OP_MOV  = 5'd4;
    localparam logic [4:0] OP_LHI  = 5'd5;
    localparam logic [4:0] OP_LLI  = 5'd6;
    localparam logic [4:0] OP_LDR  = 5'd7;
    localparam logic [4:0] OP_STR  = 5'd8;
    localparam logic [4:0] OP_B    = 5'd9;
    localparam logic [4:0] OP_J    = 5'd10;
    localparam logic [4:0] OP_JR   = 5'd11;
    localparam logic [4:0] OP_JAL  = 5'd12;
    localparam logic [4:0] OP_HLT  = 5'd13;

    // Next-PC select
    localparam logic [1:0] JMP_PC1 = 2'b00;
    localparam logic [1:0] JMP_IMM = 2'b01;
    localparam logic [1:0] JMP_REG = 2'b10;

    // Branch condition select (ALUopcode during OP_B)
    localparam logic [1:0] COND_AL = 2'b00;
    localparam logic [1:0] COND_Z  = 2'b01;
    localparam logic [1:0] COND_N  = 2'b10;
    localparam logic [1:0] COND_C  = 2'b11;

    typedef struct packed {
        logic       buff_pc;
        logic       buff_memins;
        logic       buff_psw;
        logic       we_mem;
        logic       mem_resource;
        logic       rb_resource;
        logic       we_rf;
        logic       wb_resource;
        logic       pcplus1_or_wb;
        logic       oprand_b;
        logic       li;
        logic       alu_op;
        logic       flag;
        logic       li_or_mov;
        logic       alu_or_not;
        logic       branch_en;
        logic [1:0] jump;
        logic       halted;
    } ctrl_t;

    function automatic logic op_is_legal(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_ADDI, OP_CMP, OP_MOV, OP_LHI, OP_LLI,
            OP_LDR, OP_STR, OP_B, OP_J, OP_JR, OP_JAL, OP_HLT: return 1'b1;
            default:                                           return 1'b0;
        endcase
    endfunction

    // nzc = {N,Z,C}
    function automatic logic branch_cond(input logic [1:0] sel, input logic [2:0] nzc);
        case (sel)
            COND_AL: return 1'b1;
            COND_Z:  return nzc[1];
            COND_N:  return nzc[2];
            COND_C:  return nzc[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle.
// master: controller side (takes TBorNot, opcode, ALUopcode, PSW_NZC; drives
//         all control strobes, Jump, halted and the state code).
// slave:  datapath / bench side (mirror directions).
interface multicycle_controller_if;
    logic       TBorNot;
    logic [4:0] opcode;
    logic [1:0] ALUopcode;
    logic [2:0] PSW_NZC;

    logic       Buff_PC;
    logic       Buff_MEMIns;
    logic       Buff_PSW;
    logic       WE_MEM;
    logic       MEMresource;
    logic       RBresource;
    logic       WE_RF;
    logic       WBresource;
    logic       PCplus1orWB;
    logic       oprandB;
    logic       LI;
    logic       ALUop;
    logic       Flag;
    logic       LIorMOV;
    logic       ALUorNot;
    logic       Branch;
    logic [1:0] Jump;
    logic       halted;
    logic [2:0] state;

    modport master (
        input  TBorNot, opcode, ALUopcode, PSW_NZC,
        output Buff_PC, Buff_MEMIns, Buff_PSW, WE_MEM, MEMresource, RBresource,
               WE_RF, WBresource, PCplus1orWB, oprandB, LI, ALUop, Flag,
               LIorMOV, ALUorNot, Branch, Jump, halted, state
    );

    modport slave (
        output TBorNot, opcode, ALUopcode, PSW_NZC,
        input  Buff_PC, Buff_MEMIns, Buff_PSW, WE_MEM, MEMresource, RBresource,
               WE_RF, WBresource, PCplus1orWB, oprandB, LI, ALUop, Flag,
               LIorMOV, ALUorNot, Branch, Jump, halted, state
    );
endinterface

// File: rtl/ctrl_decode.sv
// Purely combinational per-opcode control decode.
// Inputs:  state (current FSM state), op (opcode latched on entry to DECODE).
// Output:  ctrl  (full control vector; branch_en is later qualified by the
//          live PSW flags in the top level).
module ctrl_decode
    import multicycle_controller_pkg::*;
(
    input  state_t     state,
    input  logic [4:0] op,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl      = '0;
        ctrl.jump = JMP_PC1;
        case (state)
            S_FETCH: begin
                ctrl.buff_memins = 1'b1;
            end
            S_DECODE: begin
                ctrl.rb_resource = (op == OP_STR);
            end
            S_EXECUTE: begin
                ctrl.flag      = op inside {OP_ADD, OP_SUB, OP_CMP};
                ctrl.buff_psw  = op inside {OP_ADD, OP_SUB, OP_CMP};
                ctrl.alu_op    = op inside {OP_SUB, OP_CMP};
                ctrl.oprand_b  = op inside {OP_LDR, OP_STR, OP_ADDI};
                ctrl.li        = (op == OP_LHI);
                ctrl.li_or_mov = op inside {OP_LHI, OP_LLI};
            end
            S_MEMORY: begin
                ctrl.mem_resource = op inside {OP_LDR, OP_STR};
                ctrl.we_mem       = (op == OP_STR);
            end
            S_WRITEBACK: begin
                // Undefined opcodes fall through here as a NOP: PC+1, no writes.
                ctrl.buff_pc       = 1'b1;
                ctrl.we_rf         = op inside {OP_ADD, OP_SUB, OP_ADDI, OP_MOV,
                                                OP_LHI, OP_LLI, OP_LDR, OP_JAL};
                ctrl.wb_resource   = (op == OP_LDR);
                ctrl.alu_or_not    = op inside {OP_ADD, OP_SUB, OP_ADDI};
                ctrl.pcplus1_or_wb = (op == OP_JAL);
                ctrl.branch_en     = (op == OP_B);
                if (op inside {OP_B, OP_JAL}) begin
                    ctrl.jump = JMP_IMM;
                end else if (op == OP_JR) begin
                    ctrl.jump = JMP_REG;
                end
            end
            S_HALT: begin
                ctrl.halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle instruction controller: fixed 5-cycle Moore FSM
// (FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK) with IDLE for bench preload
// and a sticky HALT.
// Ports: clk, Rst (synchronous, active-low), bus (multicycle_controller_if
//        master: TBorNot/opcode/ALUopcode/PSW_NZC in; control strobes,
//        Jump, Branch, halted, state out).
// Build option: `define CTRL_ILLEGAL_TRAP_EN to send undefined opcodes to
// HALT; otherwise they run as a 5-cycle NOP.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic                    clk,
    input  logic                    Rst,
    multicycle_controller_if.master bus
);

    state_t     state_q, state_d;
    logic [4:0] op_q;
    ctrl_t      ctrl;

    always_ff @(posedge clk) begin
        if (!Rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            // Capture on the FETCH->DECODE edge so the rest of the
            // instruction is immune to later opcode changes.
            if (state_q == S_FETCH) begin
                op_q <= bus.opcode;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (!bus.TBorNot) state_d = S_FETCH;
            S_FETCH:     state_d = S_DECODE;
            S_DECODE: begin
                if (op_q == OP_HLT) begin
                    state_d = S_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
                end else if (!op_is_legal(op_q)) begin
                    state_d = S_HALT;
`endif
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE:   state_d = S_MEMORY;
            S_MEMORY:    state_d = S_WRITEBACK;
            // TBorNot is only honoured at an instruction boundary.
            S_WRITEBACK: state_d = bus.TBorNot ? S_IDLE : S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_IDLE;
        endcase
    end

    ctrl_decode u_decode (
        .state (state_q),
        .op    (op_q),
        .ctrl  (ctrl)
    );

    assign bus.Buff_PC     = ctrl.buff_pc;
    assign bus.Buff_MEMIns = ctrl.buff_memins;
    assign bus.Buff_PSW    = ctrl.buff_psw;
    assign bus.WE_MEM      = ctrl.we_mem;
    assign bus.MEMresource = ctrl.mem_resource;
    assign bus.RBresource  = ctrl.rb_resource;
    assign bus.WE_RF       = ctrl.we_rf;
    assign bus.WBresource  = ctrl.wb_resource;
    assign bus.PCplus1orWB = ctrl.pcplus1_or_wb;
    assign bus.oprandB     = ctrl.oprand_b;
    assign bus.LI          = ctrl.li;
    assign bus.ALUop       = ctrl.alu_op;
    assign bus.Flag        = ctrl.flag;
    assign bus.LIorMOV     = ctrl.li_or_mov;
    assign bus.ALUorNot    = ctrl.alu_or_not;
    assign bus.Jump        = ctrl.jump;
    assign bus.halted      = ctrl.halted;
    assign bus.state       = state_q;

    // Only combinational input->output path: flags from a CMP written at the
    // end of the previous instruction are visible in this WRITEBACK.
    assign bus.Branch = ctrl.branch_en & branch_cond(bus.ALUopcode, bus.PSW_NZC);

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    logic clk = 1'b0;
    logic Rst;
    always #5 clk = ~clk;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk (clk),
        .Rst (Rst),
        .bus (bus.master)
    );

    int tests = 0;
    int fails = 0;

    // Observed control vector, bit order matches the masks below.
    logic [18:0] obs;
    assign obs = {bus.Buff_PC, bus.Buff_MEMIns, bus.Buff_PSW, bus.WE_MEM,
                  bus.MEMresource, bus.RBresource, bus.WE_RF, bus.WBresource,
                  bus.PCplus1orWB, bus.oprandB, bus.LI, bus.ALUop, bus.Flag,
                  bus.LIorMOV, bus.ALUorNot, bus.Branch, bus.Jump, bus.halted};

    localparam logic [18:0] M_PC     = 19'h40000;
    localparam logic [18:0] M_MEMINS = 19'h20000;
    localparam logic [18:0] M_PSW    = 19'h10000;
    localparam logic [18:0] M_WEMEM  = 19'h08000;
    localparam logic [18:0] M_MEMRES = 19'h04000;
    localparam logic [18:0] M_RB     = 19'h02000;
    localparam logic [18:0] M_WERF   = 19'h01000;
    localparam logic [18:0] M_WBRES  = 19'h00800;
    localparam logic [18:0] M_PCP1   = 19'h00400;
    localparam logic [18:0] M_OPB    = 19'h00200;
    localparam logic [18:0] M_LI     = 19'h00100;
    localparam logic [18:0] M_ALUOP  = 19'h00080;
    localparam logic [18:0] M_FLAG   = 19'h00040;
    localparam logic [18:0] M_LIMOV  = 19'h00020;
    localparam logic [18:0] M_ALUNOT = 19'h00010;
    localparam logic [18:0] M_BR     = 19'h00008;
    localparam logic [18:0] M_J10    = 19'h00004;
    localparam logic [18:0] M_J01    = 19'h00002;
    localparam logic [18:0] M_HALT   = 19'h00001;

    typedef struct {
        logic [4:0]  op;
        logic [1:0]  aluop;
        logic [2:0]  psw;
        logic [18:0] ex;
        logic [18:0] mem;
        logic [18:0] wb;
    } row_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        bus.TBorNot = 1'b1;
        bus.opcode = OP_ADD;
        bus.ALUopcode = 2'b00;
        bus.PSW_NZC = 3'b000;
        repeat (3) tick();
        tests++;
        if (bus.state !== 3'd0 || obs !== 19'h0) begin
            fails++;
            $display("FAIL reset_init: state=%0d ctrl=%h, expected state=0 ctrl=00000", bus.state, obs);
        end
        Rst = 1'b1;
        tick();
        // Run ADD into EXECUTE, then reset mid-instruction
        bus.TBorNot = 1'b0;
        tick();
        tick();
        tick();
        tests++;
        if (bus.state !== 3'd3 || obs !== (M_FLAG | M_PSW)) begin
            fails++;
            $display("FAIL reset_pre_exec: state=%0d ctrl=%h, expected state=3 ctrl=%h", bus.state, obs, M_FLAG | M_PSW);
        end
        bus.TBorNot = 1'b1;
        Rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (bus.state !== 3'd0 || obs !== 19'h0) begin
                fails++;
                $display("FAIL reset_hold%0d: state=%0d ctrl=%h, expected state=0 ctrl=00000", i, bus.state, obs);
            end
        end
        Rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (bus.state !== 3'd0 || obs !== 19'h0) begin
                fails++;
                $display("FAIL reset_idle%0d: state=%0d ctrl=%h, expected state=0 ctrl=00000", i, bus.state, obs);
            end
        end
        bus.TBorNot = 1'b0;
        tick();
        tests++;
        if (bus.state !== 3'd1) begin
            fails++;
            $display("FAIL reset_leave_idle: state=%0d, expected 1", bus.state);
        end
        bus.TBorNot = 1'b1;
        repeat (5) tick();
        tests++;
        if (bus.state !== 3'd0) begin
            fails++;
            $display("FAIL reset_back_idle: state=%0d, expected 0", bus.state);
        end
    endtask

    task automatic test_lhi();
        logic [18:0] exp [5];
        exp[0] = M_MEMINS;
        exp[1] = 19'h0;
        exp[2] = M_LI | M_LIMOV;
        exp[3] = 19'h0;
        exp[4] = M_PC | M_WERF;
        bus.opcode = OP_LHI;
        bus.TBorNot = 1'b0;
        tick();
        bus.TBorNot = 1'b1;   // ignored until WRITEBACK completes
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (bus.state !== 3'(i + 1) || obs !== exp[i]) begin
                fails++;
                $display("FAIL lhi_cyc%0d: state=%0d ctrl=%h, expected state=%0d ctrl=%h", i + 1, bus.state, obs, i + 1, exp[i]);
            end
            if (i == 1) bus.opcode = OP_STR;  // must not disturb latched LHI
            tick();
        end
        tests++;
        if (bus.state !== 3'd0 || obs !== 19'h0) begin
            fails++;
            $display("FAIL lhi_to_idle: state=%0d ctrl=%h, expected state=0 ctrl=00000", bus.state, obs);
        end
    endtask

    task automatic test_str();
        logic [18:0] exp [5];
        exp[0] = M_MEMINS;
        exp[1] = M_RB;
        exp[2] = M_OPB;
        exp[3] = M_MEMRES | M_WEMEM;
        exp[4] = M_PC;
        bus.opcode = OP_STR;
        bus.TBorNot = 1'b0;
        tick();
        bus.TBorNot = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (bus.state !== 3'(i + 1) || obs !== exp[i]) begin
                fails++;
                $display("FAIL str_cyc%0d: state=%0d ctrl=%h, expected state=%0d ctrl=%h", i + 1, bus.state, obs, i + 1, exp[i]);
            end
            tick();
        end
        tests++;
        if (bus.state !== 3'd0) begin
            fails++;
            $display("FAIL str_to_idle: state=%0d, expected 0", bus.state);
        end
    endtask

    // CMP followed back-to-back by B (cond Z); pass 0 has Z set, pass 1 clear.
    task automatic test_back_to_back_branch();
        logic [18:0] exp [10];
        for (int p = 0; p < 2; p++) begin
            exp[0] = M_MEMINS;
            exp[1] = 19'h0;
            exp[2] = M_FLAG | M_PSW | M_ALUOP;
            exp[3] = 19'h0;
            exp[4] = M_PC;
            exp[5] = M_MEMINS;
            exp[6] = 19'h0;
            exp[7] = 19'h0;
            exp[8] = 19'h0;
            exp[9] = (p == 0) ? (M_PC | M_J01 | M_BR) : (M_PC | M_J01);
            bus.PSW_NZC = (p == 0) ? 3'b010 : 3'b000;
            bus.ALUopcode = COND_Z;
            bus.opcode = OP_CMP;
            bus.TBorNot = 1'b0;
            tick();
            for (int i = 0; i < 10; i++) begin
                tests++;
                if (bus.state !== 3'((i % 5) + 1) || obs !== exp[i]) begin
                    fails++;
                    $display("FAIL branch_p%0d_cyc%0d: state=%0d ctrl=%h, expected state=%0d ctrl=%h", p, i, bus.state, obs, (i % 5) + 1, exp[i]);
                end
                if (i == 4) bus.opcode = OP_B;
                if (i == 8) bus.TBorNot = 1'b1;
                if (i == 9 && p == 0) begin
                    // Branch follows the live flags within the cycle
                    bus.PSW_NZC = 3'b000;
                    #1;
                    tests++;
                    if (bus.Branch !== 1'b0) begin
                        fails++;
                        $display("FAIL branch_live_flags: Branch=%b, expected 0", bus.Branch);
                    end
                end
                tick();
            end
            tests++;
            if (bus.state !== 3'd0) begin
                fails++;
                $display("FAIL branch_p%0d_to_idle: state=%0d, expected 0", p, bus.state);
            end
        end
    endtask

    task automatic test_opcodes();
        row_t rows [13];
        rows[0]  = '{OP_ADD,  2'b00, 3'b111, M_FLAG | M_PSW,           19'h0,    M_PC | M_WERF | M_ALUNOT};
        rows[1]  = '{OP_SUB,  2'b00, 3'b000, M_FLAG | M_PSW | M_ALUOP, 19'h0,    M_PC | M_WERF | M_ALUNOT};
        rows[2]  = '{OP_ADDI, 2'b00, 3'b000, M_OPB,                    19'h0,    M_PC | M_WERF | M_ALUNOT};
        rows[3]  = '{OP_MOV,  2'b00, 3'b000, 19'h0,                    19'h0,    M_PC | M_WERF};
        rows[4]  = '{OP_LLI,  2'b00, 3'b000, M_LIMOV,                  19'h0,    M_PC | M_WERF};
        rows[5]  = '{OP_LDR,  2'b00, 3'b000, M_OPB,                    M_MEMRES, M_PC | M_WERF | M_WBRES};
        rows[6]  = '{OP_J,    2'b00, 3'b000, 19'h0,                    19'h0,    M_PC};
        rows[7]  = '{OP_JR,   2'b00, 3'b000, 19'h0,                    19'h0,    M_PC | M_J10};
        rows[8]  = '{OP_JAL,  2'b00, 3'b000, 19'h0,                    19'h0,    M_PC | M_WERF | M_PCP1 | M_J01};
        rows[9]  = '{OP_B,    2'b00, 3'b000, 19'h0,                    19'h0,    M_PC | M_J01 | M_BR};
        rows[10] = '{OP_B,    2'b10, 3'b100, 19'h0,                    19'h0,    M_PC | M_J01 | M_BR};
        rows[11] = '{OP_B,    2'b11, 3'b110, 19'h0,                    19'h0,    M_PC | M_J01};
        rows[12] = '{OP_B,    2'b11, 3'b001, 19'h0,                    19'h0,    M_PC | M_J01 | M_BR};
        for (int r = 0; r < 13; r++) begin
            logic [18:0] exp [5];
            exp[0] = M_MEMINS;
            exp[1] = 19'h0;
            exp[2] = rows[r].ex;
            exp[3] = rows[r].mem;
            exp[4] = rows[r].wb;
            bus.opcode = rows[r].op;
            bus.ALUopcode = rows[r].aluop;
            bus.PSW_NZC = rows[r].psw;
            bus.TBorNot = 1'b0;
            tick();
            bus.TBorNot = 1'b1;
            for (int i = 0; i < 5; i++) begin
                tests++;
                if (bus.state !== 3'(i + 1) || obs !== exp[i]) begin
                    fails++;
                    $display("FAIL op%0d_row%0d_cyc%0d: state=%0d ctrl=%h, expected state=%0d ctrl=%h", rows[r].op, r, i + 1, bus.state, obs, i + 1, exp[i]);
                end
                tick();
            end
            tests++;
            if (bus.state !== 3'd0 || obs !== 19'h0) begin
                fails++;
                $display("FAIL op_row%0d_to_idle: state=%0d ctrl=%h, expected state=0 ctrl=00000", r, bus.state, obs);
            end
        end
        bus.ALUopcode = 2'b00;
        bus.PSW_NZC = 3'b000;
    endtask

    task automatic test_hlt();
        bus.opcode = OP_HLT;
        bus.TBorNot = 1'b0;
        tick();
        tests++;
        if (bus.state !== 3'd1 || obs !== M_MEMINS) begin
            fails++;
            $display("FAIL hlt_fetch: state=%0d ctrl=%h, expected state=1 ctrl=%h", bus.state, obs, M_MEMINS);
        end
        tick();
        tests++;
        if (bus.state !== 3'd2 || obs !== 19'h0) begin
            fails++;
            $display("FAIL hlt_decode: state=%0d ctrl=%h, expected state=2 ctrl=00000", bus.state, obs);
        end
        tick();
        tests++;
        if (bus.state !== 3'd6 || obs !== M_HALT) begin
            fails++;
            $display("FAIL hlt_enter: state=%0d ctrl=%h, expected state=6 ctrl=%h", bus.state, obs, M_HALT);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            tests++;
            if (bus.state !== 3'd6 || bus.Buff_PC !== 1'b0 || bus.halted !== 1'b1) begin
                fails++;
                $display("FAIL hlt_hold%0d: state=%0d Buff_PC=%b halted=%b, expected 6/0/1", i, bus.state, bus.Buff_PC, bus.halted);
            end
        end
        bus.TBorNot = 1'b1;
        Rst = 1'b0;
        tick();
        tests++;
        if (bus.state !== 3'd0 || obs !== 19'h0) begin
            fails++;
            $display("FAIL hlt_reset: state=%0d ctrl=%h, expected state=0 ctrl=00000", bus.state, obs);
        end
        Rst = 1'b1;
        tick();
    endtask

    task automatic test_illegal();
        bus.opcode = 5'b11111;
        bus.TBorNot = 1'b0;
        tick();
        bus.TBorNot = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
        tick();
        tick();
        tests++;
        if (bus.state !== 3'd6 || bus.halted !== 1'b1) begin
            fails++;
            $display("FAIL illegal_trap: state=%0d halted=%b, expected 6/1", bus.state, bus.halted);
        end
        Rst = 1'b0;
        tick();
        Rst = 1'b1;
        tick();
`else
        begin
            logic [18:0] exp [5];
            exp[0] = M_MEMINS;
            exp[1] = 19'h0;
            exp[2] = 19'h0;
            exp[3] = 19'h0;
            exp[4] = M_PC;
            for (int i = 0; i < 5; i++) begin
                tests++;
                if (bus.state !== 3'(i + 1) || obs !== exp[i]) begin
                    fails++;
                    $display("FAIL illegal_nop_cyc%0d: state=%0d ctrl=%h, expected state=%0d ctrl=%h", i + 1, bus.state, obs, i + 1, exp[i]);
                end
                tick();
            end
        end
`endif
        tests++;
        if (bus.state !== 3'd0 || obs !== 19'h0) begin
            fails++;
            $display("FAIL illegal_to_idle: state=%0d ctrl=%h, expected state=0 ctrl=00000", bus.state, obs);
        end
    endtask

    initial begin
        Rst = 1'b0;
        bus.TBorNot = 1'b1;
        bus.opcode = OP_ADD;
        bus.ALUopcode = 2'b00;
        bus.PSW_NZC = 3'b000;
        test_reset();
        test_lhi();
        test_str();
        test_back_to_back_branch();
        test_opcodes();
        test_hlt();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
